// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the push-button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } deb_state_t;

    // Counter only ever reaches cycles-1, but sizing for cycles keeps the compare constant in range.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel: synchroniser chain followed by a stable-run qualifier FSM.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic out_level,
    output logic busy
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   sync;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
        sync   = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LOW: begin
                if (sync) begin
                    state_d = S_RISE;
                    cnt_d   = CW'(1);
                end
            end
            S_RISE: begin
                if (!sync) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HIGH: begin
                if (!sync) begin
                    state_d = S_FALL;
                    cnt_d   = CW'(1);
                end
            end
            S_FALL: begin
                if (sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it, so they track state_q exactly.
    always_comb begin
        out_d  = (state_d == S_HIGH) || (state_d == S_FALL);
        busy_d = (state_d == S_RISE) || (state_d == S_FALL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign out_level = out_q;
    assign busy      = busy_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel synchroniser + debouncer; channels are fully independent.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int N_INPUTS        = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] in_raw,
    output logic [N_INPUTS-1:0] out_level,
    output logic [N_INPUTS-1:0] busy
);

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .in_raw    (in_raw[i]),
            .out_level (out_level[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed and random stimulus checked against a stable-run-length reference model.
module tb_button_debouncer;

    localparam int N    = 2;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] in_raw;
    logic [N-1:0] out_level;
    logic [N-1:0] busy;

    int total = 0;
    int bad   = 0;

    // Reference model: raw history delayed SYNC edges, accepted level, run of disagreeing samples.
    logic [N-1:0] hist[$];
    logic [N-1:0] mlev;
    int           mrun[N];
    int           model_rises = 0;
    int           dut_rises   = 0;
    logic         prev_out0   = 1'b0;

    button_debouncer #(
        .N_INPUTS        (N),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_raw    (in_raw),
        .out_level (out_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] raw, input logic rst);
        logic [N-1:0] f;
        if (!rst) begin
            hist.delete();
            for (int s = 0; s < SYNC; s++) hist.push_back('0);
            mlev = '0;
            for (int c = 0; c < N; c++) mrun[c] = 0;
        end else begin
            f = hist.pop_front();
            hist.push_back(raw);
            for (int c = 0; c < N; c++) begin
                if (f[c] != mlev[c]) begin
                    mrun[c]++;
                    if (mrun[c] == DEB) begin
                        mlev[c] = ~mlev[c];
                        mrun[c] = 0;
                        if (c == 0 && mlev[c]) model_rises++;
                    end
                end else begin
                    mrun[c] = 0;
                end
            end
        end
    endtask

    function automatic logic [N-1:0] mbusy();
        logic [N-1:0] b;
        for (int c = 0; c < N; c++) b[c] = (mrun[c] > 0);
        return b;
    endfunction

    // One clock edge with the given inputs, then compare against the model.
    task automatic tick(input logic [N-1:0] raw, input logic rst, input string tag);
        in_raw = raw;
        reset  = rst;
        @(posedge clk);
        model_edge(raw, rst);
        #1;
        check({tag, ".lvl"}, out_level, mlev);
        check({tag, ".busy"}, busy, mbusy());
        if (out_level[0] && !prev_out0) dut_rises++;
        prev_out0 = out_level[0];
    endtask

    initial begin
        logic [N-1:0] r;
        in_raw = '0;
        reset  = 1'b0;

        // Reset held with raw high, then release.
        for (int i = 0; i < 3; i++) begin
            tick(2'b11, 1'b0, "rst_hold");
            check("rst_zero_lvl", out_level, 2'b00);
            check("rst_zero_busy", busy, 2'b00);
        end
        for (int i = 0; i < 5; i++) tick(2'b11, 1'b1, "rel");
        check("rel_not_yet", out_level, 2'b00);
        tick(2'b11, 1'b1, "rel");
        check("rel_latency", out_level, 2'b11);

        // Return to idle.
        for (int i = 0; i < 8; i++) tick(2'b00, 1'b1, "idle");
        check("idle_low", out_level, 2'b00);

        // Clean press on channel 0.
        tick(2'b01, 1'b1, "press");
        tick(2'b01, 1'b1, "press");
        check("press_busy_k1", busy, 2'b00);
        tick(2'b01, 1'b1, "press");
        check("press_busy_k2", busy, 2'b01);
        tick(2'b01, 1'b1, "press");
        tick(2'b01, 1'b1, "press");
        check("press_k4", {busy[0], out_level[0]}, 2'b10);
        tick(2'b01, 1'b1, "press");
        check("press_k5", out_level, 2'b01);

        // Release with a 2-cycle glitch, then a permanent drop.
        tick(2'b00, 1'b1, "glitch");
        tick(2'b00, 1'b1, "glitch");
        for (int i = 0; i < 6; i++) tick(2'b01, 1'b1, "glitch");
        check("glitch_ignored", out_level, 2'b01);
        for (int i = 0; i < 5; i++) tick(2'b00, 1'b1, "drop");
        check("drop_not_yet", out_level, 2'b01);
        tick(2'b00, 1'b1, "drop");
        check("drop_latency", out_level, 2'b00);

        // Bounce: 3-cycle high phases separated by single lows, then hold.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3; i++) tick(2'b01, 1'b1, "bounce");
            if (p < 2) tick(2'b00, 1'b1, "bounce");
        end
        check("bounce_rejected", out_level, 2'b00);
        for (int i = 0; i < 6; i++) tick(2'b01, 1'b1, "bounce_hold");
        check("bounce_final", out_level, 2'b01);
        for (int i = 0; i < 10; i++) tick(2'b00, 1'b1, "idle2");

        // Simultaneous rise, reset mid-qualification, release with raw high.
        for (int i = 0; i < 3; i++) tick(2'b11, 1'b1, "simul");
        check("simul_busy", busy, 2'b11);
        tick(2'b11, 1'b0, "simul_rst");
        check("simul_rst_lvl", out_level, 2'b00);
        check("simul_rst_busy", busy, 2'b00);
        for (int i = 0; i < 5; i++) tick(2'b11, 1'b1, "simul_rel");
        check("simul_not_yet", out_level, 2'b00);
        tick(2'b11, 1'b1, "simul_rel");
        check("simul_both", out_level, 2'b11);

        // Random bouncing with occasional resets.
        r = 2'b11;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 4) == 0) r[c] = ~r[c];
            tick(r, ($urandom_range(0, 199) != 0), "rand");
        end

        check("posedge_count", 2'(dut_rises == model_rises), 2'b01);
        if (dut_rises != model_rises)
            $display("FAIL rises dut=%0d model=%0d", dut_rises, model_rises);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
